msi_cache_block: RTL and testbench

- One direct-mapped, single-line cache block with 3-bit tag and 4-bit data, kept coherent by MSI snooping.
- Combines line storage, the CPU-side MSI controller and the bus-side snoop controller in one clocked block.
- Sits between a CPU request port and a shared snooping bus.
- Replaces the gated-clock, register-plus-separate-state-machine arrangement with one synchronous block.

---
 rtl/msi_cache_block_if.sv | 45 ++++
 rtl/msi_cache_block.sv | 195 +++++++++++++++++++
 tb/tb_msi_cache_block.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/msi_cache_block_if.sv
// CPU request port, fill reply and snooping-bus signals of one MSI cache block.
// The slave modport is the cache's view; the master modport is whoever drives it.
interface msi_cache_block_if;
    logic       cpu_valid;
    logic       cpu_write;
    logic [2:0] cpu_address;
    logic [3:0] cpu_data;
    logic       ready;
    logic       done;
    logic [3:0] data_out;
    logic       fill_valid;
    logic [3:0] fill_data;
    logic       snoop_valid;
    logic [1:0] snoop_op;
    logic [2:0] snoop_address;
    logic       bus_read_miss;
    logic       bus_write_miss;
    logic       bus_invalidate;
    logic       bus_write_back;
    logic [2:0] bus_address;
    logic [3:0] bus_data;
    logic [1:0] line_state;
    logic [2:0] line_address;
    logic [3:0] line_data;

    modport slave (
        input  cpu_valid, cpu_write, cpu_address, cpu_data,
        input  fill_valid, fill_data,
        input  snoop_valid, snoop_op, snoop_address,
        output ready, done, data_out,
        output bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back,
        output bus_address, bus_data,
        output line_state, line_address, line_data
    );

    modport master (
        output cpu_valid, cpu_write, cpu_address, cpu_data,
        output fill_valid, fill_data,
        output snoop_valid, snoop_op, snoop_address,
        input  ready, done, data_out,
        input  bus_read_miss, bus_write_miss, bus_invalidate, bus_write_back,
        input  bus_address, bus_data,
        input  line_state, line_address, line_data
    );
endinterface

// File: rtl/msi_cache_block.sv
// Single-line direct-mapped cache block with MSI snooping: line storage, CPU-side
// controller and bus-side snoop handling in one synchronous block.
module msi_cache_block (
    input  logic                     clock,
    input  logic                     reset,
    msi_cache_block_if.slave         bus
);
    localparam logic [1:0] LINE_I = 2'b00;
    localparam logic [1:0] LINE_S = 2'b01;
    localparam logic [1:0] LINE_M = 2'b10;

    localparam logic [1:0] SNOOP_RM  = 2'b01;
    localparam logic [1:0] SNOOP_WM  = 2'b10;
    localparam logic [1:0] SNOOP_INV = 2'b11;

    typedef enum logic {ST_IDLE, ST_WAIT_FILL} ctrl_state_t;
    typedef enum logic [1:0] {MSG_NONE, MSG_RM, MSG_WM, MSG_INV} msg_t;

    ctrl_state_t r_state;
    logic [1:0]  r_line_state;
    logic [2:0]  r_line_addr;
    logic [3:0]  r_line_data;
    logic        r_req_write;
    logic [2:0]  r_req_addr;
    logic [3:0]  r_req_data;
    logic        r_pend_valid;
    msg_t        r_pend_op;
    logic [2:0]  r_pend_addr;
    logic        r_done;
    logic [3:0]  r_data_out;
    logic        r_bus_rm;
    logic        r_bus_wm;
    logic        r_bus_inv;
    logic        r_bus_wb;
    logic [2:0]  r_bus_addr;
    logic [3:0]  r_bus_data;

    logic        w_ready;
    logic        w_line_valid;
    logic        w_hit;
    logic        w_accept;
    logic        w_snoop_match;
    logic        w_snoop_wb;
    logic        w_evict_wb;
    logic        w_wb_now;
    logic        w_fill;
    msg_t        w_new_msg;
    logic [2:0]  w_new_addr;
    msg_t        w_send_op;
    logic [2:0]  w_send_addr;

    // The encoding 2'b11 is never produced but is treated as invalid if it appears.
    assign w_line_valid  = (r_line_state == LINE_S) || (r_line_state == LINE_M);
    assign w_ready       = (r_state == ST_IDLE) && !bus.snoop_valid;
    assign w_accept      = bus.cpu_valid && w_ready;
    assign w_hit         = w_line_valid && (r_line_addr == bus.cpu_address);
    assign w_snoop_match = bus.snoop_valid && w_line_valid && (bus.snoop_address == r_line_addr);
    assign w_snoop_wb    = w_snoop_match && (r_line_state == LINE_M) &&
                           ((bus.snoop_op == SNOOP_RM) || (bus.snoop_op == SNOOP_WM));
    assign w_evict_wb    = w_accept && !w_hit && (r_line_state == LINE_M);
    assign w_wb_now      = w_snoop_wb || w_evict_wb;
    // A reply cannot precede the miss message it answers, so hold off while one is queued.
    assign w_fill        = (r_state == ST_WAIT_FILL) && bus.fill_valid && !r_pend_valid;

    always_comb begin
        w_new_msg  = MSG_NONE;
        w_new_addr = bus.cpu_address;
        if (w_accept) begin
            if (w_hit) begin
                if (bus.cpu_write && (r_line_state == LINE_S)) begin
                    w_new_msg  = MSG_INV;
                    w_new_addr = r_line_addr;
                end
            end else begin
                w_new_msg = bus.cpu_write ? MSG_WM : MSG_RM;
            end
        end
    end

    assign w_send_op   = r_pend_valid ? r_pend_op   : w_new_msg;
    assign w_send_addr = r_pend_valid ? r_pend_addr : w_new_addr;

    // Snoop updates are applied first so that a fill in the same cycle overrides them.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_line_state <= LINE_I;
            r_line_addr  <= 3'b000;
            r_line_data  <= 4'h0;
            r_req_write  <= 1'b0;
            r_req_addr   <= 3'b000;
            r_req_data   <= 4'h0;
            r_pend_valid <= 1'b0;
            r_pend_op    <= MSG_NONE;
            r_pend_addr  <= 3'b000;
            r_done       <= 1'b0;
            r_data_out   <= 4'h0;
            r_bus_rm     <= 1'b0;
            r_bus_wm     <= 1'b0;
            r_bus_inv    <= 1'b0;
            r_bus_wb     <= 1'b0;
            r_bus_addr   <= 3'b000;
            r_bus_data   <= 4'h0;
        end else begin
            r_done     <= 1'b0;
            r_bus_rm   <= 1'b0;
            r_bus_wm   <= 1'b0;
            r_bus_inv  <= 1'b0;
            r_bus_wb   <= 1'b0;
            r_bus_addr <= 3'b000;
            r_bus_data <= 4'h0;

            if (w_snoop_match) begin
                case (bus.snoop_op)
                    SNOOP_RM:  if (r_line_state == LINE_M) r_line_state <= LINE_S;
                    SNOOP_WM:  r_line_state <= LINE_I;
                    SNOOP_INV: r_line_state <= LINE_I;
                    default:   ;
                endcase
            end

            // Write-back wins the bus; any other message waits in the one-entry queue.
            if (w_wb_now) begin
                r_bus_wb   <= 1'b1;
                r_bus_addr <= r_line_addr;
                r_bus_data <= r_line_data;
                if (w_new_msg != MSG_NONE) begin
                    r_pend_valid <= 1'b1;
                    r_pend_op    <= w_new_msg;
                    r_pend_addr  <= w_new_addr;
                end
            end else begin
                r_pend_valid <= 1'b0;
                case (w_send_op)
                    MSG_RM:  begin r_bus_rm  <= 1'b1; r_bus_addr <= w_send_addr; end
                    MSG_WM:  begin r_bus_wm  <= 1'b1; r_bus_addr <= w_send_addr; end
                    MSG_INV: begin r_bus_inv <= 1'b1; r_bus_addr <= w_send_addr; end
                    default: ;
                endcase
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_hit) begin
                            r_done <= 1'b1;
                            if (bus.cpu_write) begin
                                r_line_data  <= bus.cpu_data;
                                r_line_state <= LINE_M;
                                r_data_out   <= bus.cpu_data;
                            end else begin
                                r_data_out <= r_line_data;
                            end
                        end else begin
                            r_req_write <= bus.cpu_write;
                            r_req_addr  <= bus.cpu_address;
                            r_req_data  <= bus.cpu_data;
                            r_state     <= ST_WAIT_FILL;
                        end
                    end
                end
                ST_WAIT_FILL: begin
                    if (w_fill) begin
                        r_line_addr <= r_req_addr;
                        r_done      <= 1'b1;
                        r_state     <= ST_IDLE;
                        if (r_req_write) begin
                            r_line_data  <= r_req_data;
                            r_line_state <= LINE_M;
                            r_data_out   <= r_req_data;
                        end else begin
                            r_line_data  <= bus.fill_data;
                            r_line_state <= LINE_S;
                            r_data_out   <= bus.fill_data;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.ready          = w_ready;
    assign bus.done           = r_done;
    assign bus.data_out       = r_data_out;
    assign bus.bus_read_miss  = r_bus_rm;
    assign bus.bus_write_miss = r_bus_wm;
    assign bus.bus_invalidate = r_bus_inv;
    assign bus.bus_write_back = r_bus_wb;
    assign bus.bus_address    = r_bus_addr;
    assign bus.bus_data       = r_bus_data;
    assign bus.line_state     = r_line_state;
    assign bus.line_address   = r_line_addr;
    assign bus.line_data      = r_line_data;
endmodule

// File: tb/tb_msi_cache_block.sv
// Directed bench for msi_cache_block: walks the MSI transitions, the eviction
// write-back ordering, snoop effects and reset during an outstanding miss.
module tb_msi_cache_block;
    logic clock;
    logic reset;
    int   checkCount;
    int   errorCount;

    msi_cache_block_if busIf ();

    msi_cache_block dut (
        .clock (clock),
        .reset (reset),
        .bus   (busIf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic cpuValid, input logic cpuWrite, input logic [2:0] cpuAddr,
                                 input logic [3:0] cpuData, input logic fillValid, input logic [3:0] fillData,
                                 input logic snoopValid, input logic [1:0] snoopOp, input logic [2:0] snoopAddr);
        busIf.cpu_valid     = cpuValid;
        busIf.cpu_write     = cpuWrite;
        busIf.cpu_address   = cpuAddr;
        busIf.cpu_data      = cpuData;
        busIf.fill_valid    = fillValid;
        busIf.fill_data     = fillData;
        busIf.snoop_valid   = snoopValid;
        busIf.snoop_op      = snoopOp;
        busIf.snoop_address = snoopAddr;
    endtask

    task automatic idleInputs();
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
    endtask

    function automatic logic [7:0] pulses();
        return {4'b0, busIf.bus_read_miss, busIf.bus_write_miss, busIf.bus_invalidate, busIf.bus_write_back};
    endfunction

    initial begin
        checkCount = 0;
        errorCount = 0;
        idleInputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checkOutput("rst_state", {6'b0, busIf.line_state}, 8'h00);
        checkOutput("rst_addr", {5'b0, busIf.line_address}, 8'h00);
        checkOutput("rst_data", {4'b0, busIf.line_data}, 8'h00);
        checkOutput("rst_done", {7'b0, busIf.done}, 8'h00);
        checkOutput("rst_pulses", pulses(), 8'h00);
        checkOutput("rst_ready", {7'b0, busIf.ready}, 8'h01);

        // Read miss on an invalid line, then fill with A.
        applyStimulus(1'b1, 1'b0, 3'b000, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("rm_pulses", pulses(), 8'h08);
        checkOutput("rm_addr", {5'b0, busIf.bus_address}, 8'h00);
        checkOutput("rm_ready", {7'b0, busIf.ready}, 8'h00);
        checkOutput("rm_done", {7'b0, busIf.done}, 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 4'hA, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("fill_done", {7'b0, busIf.done}, 8'h01);
        checkOutput("fill_dout", {4'b0, busIf.data_out}, 8'h0A);
        checkOutput("fill_state", {6'b0, busIf.line_state}, 8'h01);
        checkOutput("fill_pulses", pulses(), 8'h00);

        // Write hit in S: invalidate and upgrade to M.
        applyStimulus(1'b1, 1'b1, 3'b000, 4'h5, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("wh_pulses", pulses(), 8'h02);
        checkOutput("wh_addr", {5'b0, busIf.bus_address}, 8'h00);
        checkOutput("wh_done", {7'b0, busIf.done}, 8'h01);
        checkOutput("wh_dout", {4'b0, busIf.data_out}, 8'h05);
        checkOutput("wh_state", {6'b0, busIf.line_state}, 8'h02);
        checkOutput("wh_data", {4'b0, busIf.line_data}, 8'h05);

        // Read hit in M: silent.
        applyStimulus(1'b1, 1'b0, 3'b000, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("rh_done", {7'b0, busIf.done}, 8'h01);
        checkOutput("rh_dout", {4'b0, busIf.data_out}, 8'h05);
        checkOutput("rh_pulses", pulses(), 8'h00);
        checkOutput("rh_state", {6'b0, busIf.line_state}, 8'h02);

        // Write miss evicting a modified line: write-back first, miss next cycle.
        applyStimulus(1'b1, 1'b1, 3'b010, 4'h7, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("ev_wb_pulses", pulses(), 8'h01);
        checkOutput("ev_wb_addr", {5'b0, busIf.bus_address}, 8'h00);
        checkOutput("ev_wb_data", {4'b0, busIf.bus_data}, 8'h05);
        tick();
        checkOutput("ev_wm_pulses", pulses(), 8'h04);
        checkOutput("ev_wm_addr", {5'b0, busIf.bus_address}, 8'h02);
        checkOutput("ev_wm_bdata", {4'b0, busIf.bus_data}, 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 4'hF, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("ev_fill_addr", {5'b0, busIf.line_address}, 8'h02);
        checkOutput("ev_fill_data", {4'b0, busIf.line_data}, 8'h07);
        checkOutput("ev_fill_state", {6'b0, busIf.line_state}, 8'h02);
        checkOutput("ev_fill_done", {7'b0, busIf.done}, 8'h01);
        checkOutput("ev_fill_dout", {4'b0, busIf.data_out}, 8'h07);

        // Snoops against M@010.
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 2'b01, 3'b010);
        #1;
        checkOutput("snp_ready", {7'b0, busIf.ready}, 8'h00);
        tick();
        idleInputs();
        checkOutput("snp_rm_pulses", pulses(), 8'h01);
        checkOutput("snp_rm_addr", {5'b0, busIf.bus_address}, 8'h02);
        checkOutput("snp_rm_data", {4'b0, busIf.bus_data}, 8'h07);
        checkOutput("snp_rm_state", {6'b0, busIf.line_state}, 8'h01);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 2'b11, 3'b010);
        tick();
        idleInputs();
        checkOutput("snp_inv_state", {6'b0, busIf.line_state}, 8'h00);
        checkOutput("snp_inv_pulses", pulses(), 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 2'b10, 3'b011);
        tick();
        idleInputs();
        checkOutput("snp_wm_state", {6'b0, busIf.line_state}, 8'h00);
        checkOutput("snp_wm_addr", {5'b0, busIf.line_address}, 8'h02);
        checkOutput("snp_wm_pulses", pulses(), 8'h00);

        // Bring in S@001, then snoop read miss (no change) and write miss (invalidate).
        applyStimulus(1'b1, 1'b0, 3'b001, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("s1_rm_pulses", pulses(), 8'h08);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 4'h3, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("s1_state", {6'b0, busIf.line_state}, 8'h01);
        checkOutput("s1_data", {4'b0, busIf.line_data}, 8'h03);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 2'b01, 3'b001);
        tick();
        idleInputs();
        checkOutput("s1_snprm_state", {6'b0, busIf.line_state}, 8'h01);
        checkOutput("s1_snprm_pulses", pulses(), 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b0, 4'h0, 1'b1, 2'b10, 3'b001);
        tick();
        idleInputs();
        checkOutput("s1_snpwm_state", {6'b0, busIf.line_state}, 8'h00);
        checkOutput("s1_snpwm_pulses", pulses(), 8'h00);

        // Reset while waiting for a fill; the late fill must be ignored.
        applyStimulus(1'b1, 1'b0, 3'b011, 4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("wf_pulses", pulses(), 8'h08);
        checkOutput("wf_addr", {5'b0, busIf.bus_address}, 8'h03);
        checkOutput("wf_ready", {7'b0, busIf.ready}, 8'h00);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("wfr_state", {6'b0, busIf.line_state}, 8'h00);
        checkOutput("wfr_ready", {7'b0, busIf.ready}, 8'h01);
        checkOutput("wfr_done", {7'b0, busIf.done}, 8'h00);
        checkOutput("wfr_dout", {4'b0, busIf.data_out}, 8'h00);
        applyStimulus(1'b0, 1'b0, 3'd0, 4'h0, 1'b1, 4'h9, 1'b0, 2'b00, 3'd0);
        tick();
        idleInputs();
        checkOutput("late_fill_done", {7'b0, busIf.done}, 8'h00);
        checkOutput("late_fill_state", {6'b0, busIf.line_state}, 8'h00);
        checkOutput("late_fill_data", {4'b0, busIf.line_data}, 8'h00);
        checkOutput("late_fill_ready", {7'b0, busIf.ready}, 8'h01);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end
endmodule
